// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the multi-cycle MIPS datapath.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. The memory states wait on
// Mem_Ready and abort with a one-cycle Bus_Error pulse after MEM_TIMEOUT wait
// cycles.
// Optional build macro: MULTICYCLE_ILLEGAL_TRAP_EN. When it is defined, an
// unknown opcode parks the FSM in TRAP. When it is not defined, an unknown
// opcode is treated as a NOP.
module multicycle_control #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [5:0]          Opcode,
  input  logic                Mem_Ready,
  output logic                PC_Write,
  output logic                PC_Write_Cond,
  output logic                PC_Write_Cond_Ne,
  output logic                IorD,
  output logic                Mem_Read,
  output logic                Mem_Write,
  output logic                IR_Write,
  output logic [1:0]          Reg_Dst,
  output logic [1:0]          Mem_to_Reg,
  output logic                Reg_Write,
  output logic                ALU_Src_A,
  output logic [1:0]          ALU_Src_B,
  output logic [ALU_OP_W-1:0] ALU_Op,
  output logic [1:0]          PC_Source,
  output logic                Bus_Error,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
`else
    S_JAL      = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J    = 6'd2,  OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BNE  = 6'd5,  OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10, OP_ANDI = 6'd12, OP_ORI  = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14, OP_LUI  = 6'd15, OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_error_q, bus_error_d;
  logic             mem_state, timeout;

  // State, wait counter and Bus_Error registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Next state, wait counting and timeout abort.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    wait_cnt_d  = '0;
    bus_error_d = 1'b0;
    mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout     = mem_state && !Mem_Ready && (wait_cnt_q == CNT_W'(MEM_TIMEOUT));

    case (state_q)
      S_FETCH:    if (Mem_Ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:                    state_d = S_R_EXEC;
          OP_LW, OP_SW:                state_d = S_MEM_ADDR;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI:     state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:              state_d = S_BRANCH;
          OP_J:                        state_d = S_JUMP;
          OP_JAL:                      state_d = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:                     state_d = S_TRAP;
`else
          default:                     state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        if (Opcode == OP_LW)      state_d = S_MEM_RD;
        else if (Opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD:   if (Mem_Ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (Mem_Ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JAL:  state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase

    // Ready on the timeout cycle completes normally, because timeout requires !Mem_Ready.
    if (timeout) begin
      state_d     = S_FETCH;
      bus_error_d = 1'b1;
    end else if (mem_state && !Mem_Ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Moore output decode. IR/PC load in FETCH is gated by Mem_Ready.
  always_comb begin
    PC_Write         = 1'b0;
    PC_Write_Cond    = 1'b0;
    PC_Write_Cond_Ne = 1'b0;
    IorD             = 1'b0;
    Mem_Read         = 1'b0;
    Mem_Write        = 1'b0;
    IR_Write         = 1'b0;
    Reg_Dst          = 2'b00;
    Mem_to_Reg       = 2'b00;
    Reg_Write        = 1'b0;
    ALU_Src_A        = 1'b0;
    ALU_Src_B        = 2'b00;
    ALU_Op           = '0;
    PC_Source        = 2'b00;
    Bus_Error        = bus_error_q;
    State            = state_q;

    case (state_q)
      S_FETCH: begin
        Mem_Read  = 1'b1;
        ALU_Src_B = 2'b01;
        IR_Write  = Mem_Ready;
        PC_Write  = Mem_Ready;
      end
      S_DECODE:   ALU_Src_B = 2'b11;
      S_MEM_ADDR: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
      end
      S_MEM_RD: begin
        Mem_Read = 1'b1;
        IorD     = 1'b1;
      end
      S_MEM_WB: begin
        Reg_Write  = 1'b1;
        Mem_to_Reg = 2'b01;
      end
      S_MEM_WR: begin
        Mem_Write = 1'b1;
        IorD      = 1'b1;
      end
      S_R_EXEC: begin
        ALU_Src_A = 1'b1;
        ALU_Op    = ALU_OP_W'(3'b010);
      end
      S_R_WB: begin
        Reg_Write = 1'b1;
        Reg_Dst   = 2'b01;
      end
      S_I_EXEC: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
        case (Opcode)
          OP_SLTI: ALU_Op = ALU_OP_W'(3'b101);
          OP_ANDI: ALU_Op = ALU_OP_W'(3'b011);
          OP_ORI:  ALU_Op = ALU_OP_W'(3'b100);
          OP_XORI: ALU_Op = ALU_OP_W'(3'b110);
          OP_LUI:  ALU_Op = ALU_OP_W'(3'b111);
          default: ALU_Op = ALU_OP_W'(3'b000);
        endcase
      end
      S_I_WB:     Reg_Write = 1'b1;
      S_BRANCH: begin
        ALU_Src_A        = 1'b1;
        ALU_Op           = ALU_OP_W'(3'b001);
        PC_Source        = 2'b01;
        PC_Write_Cond    = (Opcode == OP_BEQ);
        PC_Write_Cond_Ne = (Opcode == OP_BNE);
      end
      S_JUMP: begin
        PC_Write  = 1'b1;
        PC_Source = 2'b10;
      end
      S_JAL: begin
        PC_Write   = 1'b1;
        PC_Source  = 2'b10;
        Reg_Write  = 1'b1;
        Reg_Dst    = 2'b10;
        Mem_to_Reg = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. An instruction-level model predicts the
// state path and control word on every cycle. Directed state traces carry
// hand-computed literal expectations.
module tb_multicycle_control;
  localparam int ALU_OP_W    = 3;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 8;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       Mem_Ready = 1'b0;
  logic       PC_Write, PC_Write_Cond, PC_Write_Cond_Ne, IorD, Mem_Read, Mem_Write;
  logic       IR_Write, Reg_Write, ALU_Src_A, Bus_Error;
  logic [1:0] Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Source;
  logic [ALU_OP_W-1:0] ALU_Op;
  logic [3:0] State;

  multicycle_control #(.ALU_OP_W(ALU_OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond), .PC_Write_Cond_Ne(PC_Write_Cond_Ne),
    .IorD(IorD), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Reg_Dst(Reg_Dst), .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write),
    .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Op(ALU_Op),
    .PC_Source(PC_Source), .Bus_Error(Bus_Error), .State(State)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [24:0] dut_vec;
  assign dut_vec = {PC_Write, PC_Write_Cond, PC_Write_Cond_Ne, IorD, Mem_Read, Mem_Write,
                    IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B,
                    ALU_Op, PC_Source, Bus_Error, State};

  // Instruction-level model: the current step, the remaining steps of the
  // instruction, the failed memory-wait cycles, and the pending bus-error pulse.
  int   m_state = 0;
  int   m_waited = 0;
  logic m_bus = 1'b0;
  int   m_path[$];

  task automatic load_path(input logic [5:0] op);
    m_path.delete();
    case (op)
      6'd0:                           begin m_path.push_back(6); m_path.push_back(7); end
      6'd35: begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
      6'd43:                          begin m_path.push_back(2); m_path.push_back(5); end
      6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15: begin m_path.push_back(8); m_path.push_back(9); end
      6'd4, 6'd5:                     m_path.push_back(10);
      6'd2:                           m_path.push_back(11);
      6'd3:                           m_path.push_back(12);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      default:                        m_path.push_back(13);
`else
      default: ;
`endif
    endcase
  endtask

  task automatic advance();
    m_waited = 0;
    if (m_state == 0) m_state = 1;
    else if (m_state == 13) m_state = 13;
    else begin
      if (m_state == 1) load_path(Opcode);
      m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_state = 0; m_waited = 0; m_bus = 1'b0; m_path.delete();
    end else begin
      m_bus = 1'b0;
      if (m_state == 0 || m_state == 3 || m_state == 5) begin
        if (Mem_Ready) advance();
        else if (m_waited >= MEM_TIMEOUT) begin
          m_bus = 1'b1; m_state = 0; m_waited = 0; m_path.delete();
        end else m_waited++;
      end else advance();
    end
  end

  function automatic logic [24:0] model_vec(input int st, input logic [5:0] op,
                                            input logic rdy, input logic bus);
    logic pcw, pcc, pcn, iord, mr, mw, irw, rw, sa;
    logic [1:0] rd, m2r, sb, pcs;
    logic [2:0] aop;
    {pcw, pcc, pcn, iord, mr, mw, irw, rw, sa} = '0;
    {rd, m2r, sb, pcs} = '0;
    aop = 3'd0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 3'b010; end
      7:  begin rw = 1; rd = 2'b01; end
      8: begin
        sa = 1; sb = 2'b10;
        case (op)
          6'd10: aop = 3'd5;
          6'd12: aop = 3'd3;
          6'd13: aop = 3'd4;
          6'd14: aop = 3'd6;
          6'd15: aop = 3'd7;
          default: aop = 3'd0;
        endcase
      end
      9:  rw = 1;
      10: begin sa = 1; aop = 3'b001; pcs = 2'b01; pcc = (op == 6'd4); pcn = (op == 6'd5); end
      11: begin pcw = 1; pcs = 2'b10; end
      12: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      default: ;
    endcase
    return {pcw, pcc, pcn, iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, bus, 4'(st)};
  endfunction

  // Compare DUT to model on every falling edge out of reset.
  always @(negedge Clk) begin
    if (Reset_n) check($sformatf("ctrl_word(model_state=%0d)", m_state),
                       32'(dut_vec), 32'(model_vec(m_state, Opcode, Mem_Ready, m_bus)));
  end

  // Directed steps: drive inputs at posedge+2, check the state at posedge+3.
  task automatic drive(input logic [5:0] op, input logic rdy, input int exp_st);
    Opcode = op; Mem_Ready = rdy;
    #1;
    check($sformatf("state(op=%0d)", op), 32'(State), 32'(exp_st));
  endtask

  task automatic next();
    @(posedge Clk); #2;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #3;
    check("reset_state", 32'(State), 32'd0);
    check("reset_mem_read", 32'(Mem_Read), 32'd1);
    check("reset_iord", 32'(IorD), 32'd0);
    check("reset_bus_error", 32'(Bus_Error), 32'd0);
    @(posedge Clk); #2;
    Reset_n = 1'b1;

    // R-type with zero wait: 0,1,6,7,0.
    drive(6'd0, 1'b1, 0); check("fetch_ir_write", 32'(IR_Write), 32'd1);
    check("fetch_pc_write", 32'(PC_Write), 32'd1); next();
    drive(6'd0, 1'b0, 1); next();
    drive(6'd0, 1'b0, 6); check("rexec_reg_write", 32'(Reg_Write), 32'd0); next();
    drive(6'd0, 1'b0, 7); check("rwb_reg_write", 32'(Reg_Write), 32'd1);
    check("rwb_reg_dst", 32'(Reg_Dst), 32'd1); next();
    drive(6'd0, 1'b0, 0); check("fetch_wait_ir_write", 32'(IR_Write), 32'd0); next();

    // lw, three wait cycles in MEM_RD: 0,1,2,3,3,3,3,4 then 0.
    drive(6'd35, 1'b1, 0); next();
    drive(6'd35, 1'b0, 1); next();
    drive(6'd35, 1'b0, 2); next();
    for (int i = 0; i < 3; i++) begin drive(6'd35, 1'b0, 3); next(); end
    drive(6'd35, 1'b1, 3); next();
    drive(6'd35, 1'b0, 4); check("memwb_m2r", 32'(Mem_to_Reg), 32'd1);
    check("memwb_reg_write", 32'(Reg_Write), 32'd1); next();
    drive(6'd35, 1'b0, 0); next();

    // sw with no Mem_Ready: 16 cycles in MEM_WR, then one Bus_Error pulse in FETCH.
    drive(6'd43, 1'b1, 0); next();
    drive(6'd43, 1'b0, 1); next();
    drive(6'd43, 1'b0, 2); next();
    for (int i = 0; i <= MEM_TIMEOUT; i++) begin
      drive(6'd43, 1'b0, 5); check("memwr_no_bus_error", 32'(Bus_Error), 32'd0); next();
    end
    drive(6'd43, 1'b0, 0); check("timeout_bus_error", 32'(Bus_Error), 32'd1);
    check("timeout_no_reg_write", 32'(Reg_Write), 32'd0); next();
    drive(6'd43, 1'b0, 0); check("bus_error_one_cycle", 32'(Bus_Error), 32'd0); next();

    // lw with Mem_Ready on the timeout cycle: completes normally, no Bus_Error.
    drive(6'd35, 1'b1, 0); next();
    drive(6'd35, 1'b0, 1); next();
    drive(6'd35, 1'b0, 2); next();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin drive(6'd35, 1'b0, 3); next(); end
    drive(6'd35, 1'b1, 3); next();
    drive(6'd35, 1'b0, 4); check("edge_no_bus_error", 32'(Bus_Error), 32'd0); next();
    drive(6'd35, 1'b0, 0); check("edge_fetch_no_bus_error", 32'(Bus_Error), 32'd0); next();

    // bne, then jal.
    drive(6'd5, 1'b1, 0); next();
    drive(6'd5, 1'b0, 1); next();
    drive(6'd5, 1'b0, 10); check("bne_cond_ne", 32'(PC_Write_Cond_Ne), 32'd1);
    check("bne_cond", 32'(PC_Write_Cond), 32'd0); check("bne_alu_op", 32'(ALU_Op), 32'd1); next();
    drive(6'd3, 1'b1, 0); next();
    drive(6'd3, 1'b0, 1); next();
    drive(6'd3, 1'b0, 12); check("jal_pc_write", 32'(PC_Write), 32'd1);
    check("jal_reg_dst", 32'(Reg_Dst), 32'd2); check("jal_m2r", 32'(Mem_to_Reg), 32'd2); next();

    // slti.
    drive(6'd10, 1'b1, 0); next();
    drive(6'd10, 1'b0, 1); next();
    drive(6'd10, 1'b0, 8); check("slti_alu_op", 32'(ALU_Op), 32'd5); next();
    drive(6'd10, 1'b0, 9); check("iwb_reg_write", 32'(Reg_Write), 32'd1); next();
    drive(6'd10, 1'b0, 0); next();

    // Asynchronous reset in the middle of MEM_RD.
    drive(6'd35, 1'b1, 0); next();
    drive(6'd35, 1'b0, 1); next();
    drive(6'd35, 1'b0, 2); next();
    drive(6'd35, 1'b0, 3); next();
    drive(6'd35, 1'b0, 3);
    Reset_n = 1'b0;
    #1;
    check("async_rst_state", 32'(State), 32'd0);
    check("async_rst_mem_read", 32'(Mem_Read), 32'd1);
    check("async_rst_iord", 32'(IorD), 32'd0);
    check("async_rst_bus_error", 32'(Bus_Error), 32'd0);
    next();
    Reset_n = 1'b1;

    // Illegal opcode.
    drive(6'h3F, 1'b1, 0); next();
    drive(6'h3F, 1'b0, 1); next();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      drive(6'h3F, 1'b0, 13);
      check("trap_enables", 32'(dut_vec[24:4]), 32'd0);
      next();
    end
`else
    drive(6'h3F, 1'b0, 0); next();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
